hmc7044_spi_master: RTL and testbench

Serializes single-byte local-bus requests (LB_REQ/LB_RNW/LB_ADR/LB_WDAT) from the HMC7044 register block into HMC7044 3-wire SPI frames (SCLK, SLEN, SDIO) and returns LB_RDAT/LB_ACK. Sits directly downstream of the PLL register block. Its outputs drive the FPGA SDIO tri-state buffer and the SCLK/SLEN pins. Each transfer is one 24-bit frame: R/W bit, W1W0=00, 13-bit address, 8 data bits, all MSB first.

---
 rtl/hmc7044_spi_master_if.sv | 20 ++
 rtl/hmc7044_spi_master.sv | 138 +++++++++++++
 tb/tb_hmc7044_spi_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hmc7044_spi_master_if.sv
// Local-bus handshake between the HMC7044 register block (master) and the
// SPI serializer (slave). One single-byte request is outstanding at a time.
interface hmc7044_spi_master_if;
  logic        LB_REQ;
  logic        LB_RNW;
  logic [14:0] LB_ADR;
  logic [7:0]  LB_WDAT;
  logic [7:0]  LB_RDAT;
  logic        LB_ACK;

  modport master (
    output LB_REQ, LB_RNW, LB_ADR, LB_WDAT,
    input  LB_RDAT, LB_ACK
  );

  modport slave (
    input  LB_REQ, LB_RNW, LB_ADR, LB_WDAT,
    output LB_RDAT, LB_ACK
  );
endinterface

// File: rtl/hmc7044_spi_master.sv
// HMC7044 3-wire SPI master: turns one local-bus request into a 24-bit frame
// {R/W, W1W0=00, ADR[12:0], DATA} sent MSB first, and returns LB_RDAT/LB_ACK.
module hmc7044_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  hmc7044_spi_master_if.slave        lb,
  output logic                       SPI_SCLK,
  output logic                       SPI_SLEN,
  output logic                       SPI_SDO,
  input  logic                       SPI_SDI,
  output logic                       SPI_SDIO_OE,
  output logic                       BUSY
);

  if (CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || IDLE_GAP < 1) begin : g_param_check
    $error("hmc7044_spi_master: CLK_DIV, CS_SETUP, CS_HOLD and IDLE_GAP must all be >= 1");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP) >
                           (CS_HOLD > IDLE_GAP ? CS_HOLD : IDLE_GAP) ?
                           (CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP) :
                           (CS_HOLD > IDLE_GAP ? CS_HOLD : IDLE_GAP);
  localparam int CW = $clog2(CNT_MAX) + 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_idx;
  logic [22:0]   frame_sr;   // remaining bits after the one currently on SDO
  logic          is_read;
  logic [7:0]    rx_sr;
  logic [7:0]    rdat_r;
  logic          ack_r;
  logic          adr_hi_unused;

  assign adr_hi_unused = ^lb.LB_ADR[14:13];
  assign BUSY          = (state != S_IDLE);
  assign lb.LB_ACK     = ack_r;
  assign lb.LB_RDAT    = rdat_r;

  // NOTE: every register here uses non-blocking assignment so each branch
  // reads pre-edge values (e.g. frame_sr[22] is the bit before the shift).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame_sr    <= '0;
      is_read     <= 1'b0;
      rx_sr       <= '0;
      rdat_r      <= '0;
      ack_r       <= 1'b0;
      SPI_SCLK    <= 1'b0;
      SPI_SLEN    <= 1'b1;
      SPI_SDO     <= 1'b0;
      SPI_SDIO_OE <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lb.LB_REQ) begin
            frame_sr    <= {2'b00, lb.LB_ADR[12:0], (lb.LB_RNW ? 8'h00 : lb.LB_WDAT)};
            is_read     <= lb.LB_RNW;
            SPI_SDO     <= lb.LB_RNW;
            SPI_SLEN    <= 1'b0;
            SPI_SCLK    <= 1'b0;
            SPI_SDIO_OE <= 1'b1;
            cnt         <= CW'(CS_SETUP - 1);
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt     <= CW'(CLK_DIV - 1);
            bit_idx <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!SPI_SCLK) begin
            SPI_SCLK <= 1'b1;
            cnt      <= CW'(CLK_DIV - 1);
          end else begin
            // End of a high phase: SCLK falls, read data is sampled here.
            SPI_SCLK <= 1'b0;
            if (bit_idx >= 5'd16) rx_sr <= {rx_sr[6:0], SPI_SDI};
            if (bit_idx == 5'd23) begin
              cnt   <= CW'(CS_HOLD - 1);
              state <= S_HOLD;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              SPI_SDO  <= frame_sr[22];
              frame_sr <= {frame_sr[21:0], 1'b0};
              cnt      <= CW'(CLK_DIV - 1);
              if (is_read && bit_idx == 5'd15) SPI_SDIO_OE <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            SPI_SLEN    <= 1'b1;
            SPI_SDIO_OE <= 1'b0;
            ack_r       <= 1'b1;
            if (is_read) rdat_r <= rx_sr;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          cnt   <= CW'(IDLE_GAP - 1);
          state <= S_GAP;
        end
        S_GAP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmc7044_spi_master.sv
// Bench for hmc7044_spi_master: random and directed requests, a queue-based
// scoreboard, and an SPI-side monitor that also plays the HMC7044 read data.
module tb_hmc7044_spi_master;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int IDLE_GAP = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        req  = 1'b0;
  logic        rnw  = 1'b0;
  logic [14:0] adr  = '0;
  logic [7:0]  wdat = '0;
  logic        sdi  = 1'b0;
  logic        sel  = 1'b0;   // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance

  hmc7044_spi_master_if if_a();
  hmc7044_spi_master_if if_b();
  assign if_a.LB_REQ  = req & ~sel;
  assign if_a.LB_RNW  = rnw;
  assign if_a.LB_ADR  = adr;
  assign if_a.LB_WDAT = wdat;
  assign if_b.LB_REQ  = req & sel;
  assign if_b.LB_RNW  = rnw;
  assign if_b.LB_ADR  = adr;
  assign if_b.LB_WDAT = wdat;

  logic sclk_a, slen_a, sdo_a, oe_a, busy_a;
  logic sclk_b, slen_b, sdo_b, oe_b, busy_b;

  hmc7044_spi_master #(.CLK_DIV(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)) dut_a (
    .CLK(CLK), .RST(RST), .lb(if_a),
    .SPI_SCLK(sclk_a), .SPI_SLEN(slen_a), .SPI_SDO(sdo_a), .SPI_SDI(sdi),
    .SPI_SDIO_OE(oe_a), .BUSY(busy_a)
  );

  hmc7044_spi_master #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)) dut_b (
    .CLK(CLK), .RST(RST), .lb(if_b),
    .SPI_SCLK(sclk_b), .SPI_SLEN(slen_b), .SPI_SDO(sdo_b), .SPI_SDI(sdi),
    .SPI_SDIO_OE(oe_b), .BUSY(busy_b)
  );

  logic       sclk, slen, sdo, oe, busy, ack;
  logic [7:0] rdat;
  assign sclk = sel ? sclk_b : sclk_a;
  assign slen = sel ? slen_b : slen_a;
  assign sdo  = sel ? sdo_b  : sdo_a;
  assign oe   = sel ? oe_b   : oe_a;
  assign busy = sel ? busy_b : busy_a;
  assign ack  = sel ? if_b.LB_ACK  : if_a.LB_ACK;
  assign rdat = sel ? if_b.LB_RDAT : if_a.LB_RDAT;

  typedef struct {
    logic [23:0] frame;
    logic        is_read;
    logic [7:0]  rd_byte;
    logic [7:0]  rdat;
    int          latency;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;
  int cur_div = 4;
  int n_issued = 0;
  logic [7:0] model_rdat = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI-side monitor and HMC7044 read-data model
  int          cyc = 0, bits = 0, falls = 0, high_run = 0, frames_seen = 0;
  logic        in_frame = 1'b0, prev_sclk = 1'b0, prev_slen = 1'b1;
  logic        oe_bad = 1'b0, busy_bad = 1'b0;
  logic [23:0] rx_frame = '0;

  always @(negedge CLK) begin
    if (RST) begin
      if (in_frame && exp_q.size() > 0) exp_q.delete(0);  // aborted frame never answers
      in_frame  = 1'b0;
      prev_sclk = 1'b0;
      prev_slen = 1'b1;
      sdi       = 1'b0;
      high_run  = 0;
    end else begin
      if (in_frame) cyc++;
      if (prev_slen && !slen) begin
        if (frames_seen > 0) check("gap_slen_high", (high_run >= IDLE_GAP), 1);
        check("frame_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) cur = exp_q[0];
        frames_seen++;
        in_frame = 1'b1;
        cyc = 0; bits = 0; falls = 0; high_run = 0;
        rx_frame = '0;
        oe_bad   = !oe;
        busy_bad = 1'b0;
      end
      if (slen) high_run++;
      if (in_frame && !slen) begin
        if (!busy) busy_bad = 1'b1;
        if (!prev_sclk && sclk) begin
          rx_frame = {rx_frame[22:0], sdo};
          if (oe !== !(cur.is_read && bits >= 16)) oe_bad = 1'b1;
          bits++;
        end
        if (prev_sclk && !sclk) begin
          falls++;
          if (falls >= 16 && falls <= 23) sdi = cur.rd_byte[23 - falls];
        end
      end
      if (ack) begin
        check("ack_has_request", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame_bits", rx_frame, e.frame);
          check("sclk_rises", bits, 24);
          check("ack_latency", cyc, e.latency);
          check("oe_pattern_ok", oe_bad, 0);
          check("busy_in_frame", busy_bad, 0);
          check("ack_slen_oe", {slen, oe, sclk}, 3'b100);
          check("lb_rdat", rdat, e.rdat);
        end
        in_frame = 1'b0;
      end
      prev_sclk = sclk;
      prev_slen = slen;
    end
  end

  task automatic do_xfer(input logic rnw_i, input logic [14:0] adr_i, input logic [7:0] wdat_i,
                         input logic [7:0] rd_i, input bit abort);
    exp_t e;
    int   n;
    e.frame   = {rnw_i, 2'b00, adr_i[12:0], (rnw_i ? 8'h00 : wdat_i)};
    e.is_read = rnw_i;
    e.rd_byte = rd_i;
    if (rnw_i && !abort) model_rdat = rd_i;
    e.rdat    = model_rdat;
    e.latency = CS_SETUP + 48 * cur_div + CS_HOLD;
    exp_q.push_back(e);
    n_issued++;
    @(posedge CLK); #1;
    rnw = rnw_i; adr = adr_i; wdat = wdat_i; req = 1'b1;
    if (abort) begin
      n = 0;
      while (!(in_frame && bits >= 11) && n < 1000) begin @(negedge CLK); n++; end
      check("abort_reached_bit10", (in_frame && bits >= 11), 1);
      @(posedge CLK); #1;
      RST = 1'b1; req = 1'b0;
      @(posedge CLK); #1;
      check("rst_state", {slen, sclk, oe, busy, ack}, 5'b10000);
      RST = 1'b0;
      model_rdat = 8'h00;
      n = 0;
      repeat (300) begin @(negedge CLK); if (ack) n++; end
      check("no_ack_after_abort", n, 0);
      return;
    end
    repeat (5) @(posedge CLK);
    #1;
    rnw = 1'($urandom); adr = 15'($urandom); wdat = 8'($urandom);
    n = 0;
    while (!ack && n < 2000) begin @(negedge CLK); n++; end
    check("ack_seen", ack, 1);
    @(posedge CLK); #1;
    req = 1'b0;
  endtask

  task automatic rand_xfer();
    do_xfer(1'($urandom), 15'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_rdat", rdat, 8'h00);
    check("rst_ack",  ack,  1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_slen", slen, 1'b1);
    check("rst_sdo",  sdo,  1'b0);
    check("rst_oe",   oe,   1'b0);
    check("rst_busy", busy, 1'b0);

    do_xfer(1'b0, 15'h0001, 8'h55, 8'h00, 1'b0);
    do_xfer(1'b1, 15'h0078, 8'h00, 8'hA5, 1'b0);
    do_xfer(1'b0, 15'h7FFF, 8'h3C, 8'h00, 1'b0);
    do_xfer(1'b0, 15'h0123, 8'h99, 8'h00, 1'b1);
    do_xfer(1'b0, 15'h0042, 8'h81, 8'h00, 1'b0);
    do_xfer(1'b1, 15'h0078, 8'h00, 8'hA5, 1'b0);
    do_xfer(1'b0, 15'h0010, 8'h12, 8'h00, 1'b0);
    repeat (6) rand_xfer();

    repeat (10) @(posedge CLK);
    #1;
    sel = 1'b1; cur_div = 1; model_rdat = 8'h00;
    do_xfer(1'b1, 15'h0078, 8'h00, 8'hA5, 1'b0);
    do_xfer(1'b0, 15'h0010, 8'h12, 8'h00, 1'b0);
    repeat (6) rand_xfer();

    repeat (50) @(posedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("frame_count", frames_seen, n_issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
